// File: rtl/deser16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : deser16_pkg                                             |
// | Desc    : Shared widths and FSM state encoding for deser16.       |
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
package deser16_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage : deser16_pkg
`default_nettype wire

// File: rtl/and16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : and16                                                   |
// | Desc    : Standard 16-input AND reduction cell.                   |
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
module and16 (
    input  logic [15:0] i_a,
    output logic        o_y
);

    assign o_y = &i_a;

endmodule : and16
`default_nettype wire

// File: rtl/deser16_shreg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : deser16_shreg                                           |
// | Desc    : 16-bit shift register with 4-bit wrapping bit counter.  |
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
module deser16_shreg
    import deser16_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [WORD_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_cnt
);

    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] w_word_d;
    logic [CNT_W-1:0]  w_cnt_d;
    logic [WORD_W-1:0] w_shifted;

    // LSB-first enters at the top so the first bit ends in word[0] after 16 shifts
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_word[WORD_W-2:0], i_bit};
        end else begin : g_lsb_first
            assign w_shifted = {i_bit, r_word[WORD_W-1:1]};
        end
    endgenerate

    always_comb begin
        w_word_d = r_word;
        w_cnt_d  = r_cnt;
        if (i_clr) begin
            w_word_d = '0;
            w_cnt_d  = '0;
        end else if (i_shift) begin
            w_word_d = w_shifted;
            w_cnt_d  = r_cnt + CNT_W'(1);
        end
    end

    dff #(.W(WORD_W)) u_word_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_word_d),
        .o_q (r_word)
    );

    dff #(.W(CNT_W)) u_cnt_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_cnt_d),
        .o_q (r_cnt)
    );

    assign o_word = r_word;
    assign o_cnt  = r_cnt;

endmodule : deser16_shreg
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dff                                                     |
// | Desc    : Standard W-bit D flip-flop, synchronous reset to zero.  |
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : dff
`default_nettype wire

// File: rtl/deser16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : deser16                                                 |
// | Desc    : Serial-to-16-bit deserializer with valid/ready handshake.|
// |           Define DESER16_PARITY_EN for a trailing even-parity bit.|
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
module deser16
    import deser16_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              all_ones,
    output logic              par_err
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic [WORD_W-1:0] r_word;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_shift;
    logic              w_clr;
    logic              w_last_data;
    logic              w_and_all;

    // State register
    dff #(.W(2)) u_state_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_state_d),
        .o_q (r_state)
    );

    assign w_last_data = (r_cnt == {CNT_W{1'b1}});

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_accept && w_last_data) begin
`ifdef DESER16_PARITY_EN
                    w_state_d = ST_PAR;
`else
                    w_state_d = ST_HOLD;
`endif
                end
            end
            ST_PAR: begin
                if (w_accept) w_state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (word_ready) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        bit_ready  = !rst && (r_state != ST_HOLD);
        word_valid = (r_state == ST_HOLD);
        w_accept   = bit_valid && bit_ready;
        w_shift    = w_accept && (r_state != ST_PAR);
        w_clr      = word_valid && word_ready;
    end

    deser16_shreg #(.MSB_FIRST(MSB_FIRST)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_shift (w_shift),
        .i_bit   (bit_in),
        .o_word  (r_word),
        .o_cnt   (r_cnt)
    );

    and16 u_and16 (
        .i_a (r_word),
        .o_y (w_and_all)
    );

    assign word     = r_word;
    assign all_ones = w_and_all && word_valid;

`ifdef DESER16_PARITY_EN
    logic r_par_bit;
    logic w_par_d;

    always_comb begin
        w_par_d = r_par_bit;
        if (w_clr) begin
            w_par_d = 1'b0;
        end else if (w_accept && (r_state == ST_PAR)) begin
            w_par_d = bit_in;
        end
    end

    dff #(.W(1)) u_par_ff (
        .clk (clk),
        .rst (rst),
        .i_d (w_par_d),
        .o_q (r_par_bit)
    );

    assign par_err = word_valid && ((^r_word) ^ r_par_bit);
`else
    assign par_err = 1'b0;
`endif

endmodule : deser16
`default_nettype wire

// File: tb/tb_deser16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_deser16                                              |
// | Desc    : Self-checking bench for deser16 (LSB- and MSB-first).   |
// | Rev     : 1.0 initial release                                     |
// +------------------------------------------------------------------+
module tb_deser16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  bit_in;
    logic [1:0]  bit_valid;
    logic [1:0]  word_ready;
    logic        bit_ready  [2];
    logic        word_valid [2];
    logic        all_ones   [2];
    logic        par_err    [2];
    logic [15:0] word       [2];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    deser16 #(.MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in[0]),
        .bit_valid  (bit_valid[0]),
        .bit_ready  (bit_ready[0]),
        .word       (word[0]),
        .word_valid (word_valid[0]),
        .word_ready (word_ready[0]),
        .all_ones   (all_ones[0]),
        .par_err    (par_err[0])
    );

    deser16 #(.MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in[1]),
        .bit_valid  (bit_valid[1]),
        .bit_ready  (bit_ready[1]),
        .word       (word[1]),
        .word_valid (word_valid[1]),
        .word_ready (word_ready[1]),
        .all_ones   (all_ones[1]),
        .par_err    (par_err[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a parity error exists only in the parity build, when the 17 bits have odd weight
    function automatic logic exp_par(input logic [15:0] d, input logic p);
`ifdef DESER16_PARITY_EN
        return (^d) ^ p;
`else
        return 1'b0;
`endif
    endfunction

    // Serialize data in the order the instance expects; random idle gaps carry junk on bit_in
    task automatic send_word(input int sel, input logic [15:0] data, input int gap_max, input logic pbit);
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gaps) begin
                bit_valid[sel] = 1'b0;
                bit_in[sel]    = 1'($urandom);
                tick();
            end
            bit_valid[sel] = 1'b1;
            bit_in[sel]    = (sel == 1) ? data[15 - i] : data[i];
            tick();
        end
`ifdef DESER16_PARITY_EN
        bit_valid[sel] = 1'b1;
        bit_in[sel]    = pbit;
        tick();
`else
        if (pbit === 1'bx) bit_in[sel] = 1'b0;
`endif
        bit_valid[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bit_valid  = 2'b11;
        bit_in     = 2'b11;
        word_ready = 2'b00;
        #1;
        checks++;
        if (bit_ready[0] !== 1'b0) begin fails++; $display("FAIL reset_bit_ready got=%b exp=0", bit_ready[0]); end
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (word[s] !== 16'h0000) begin fails++; $display("FAIL reset_word[%0d] got=%h exp=0000", s, word[s]); end
            checks++;
            if (word_valid[s] !== 1'b0 || all_ones[s] !== 1'b0 || par_err[s] !== 1'b0) begin
                fails++; $display("FAIL reset_flags[%0d] got=%b%b%b exp=000", s, word_valid[s], all_ones[s], par_err[s]);
            end
        end
        rst       = 1'b0;
        bit_valid = 2'b00;
        #1;
        checks++;
        if (bit_ready[0] !== 1'b1 || bit_ready[1] !== 1'b1) begin
            fails++; $display("FAIL post_reset_ready got=%b%b exp=11", bit_ready[1], bit_ready[0]);
        end
    endtask

    task automatic test_back_to_back();
        word_ready[0] = 1'b1;
        send_word(0, 16'hA5C3, 0, 1'b0);
        checks++;
        if (word_valid[0] !== 1'b1) begin fails++; $display("FAIL b2b_valid got=%b exp=1", word_valid[0]); end
        checks++;
        if (word[0] !== 16'hA5C3) begin fails++; $display("FAIL b2b_word got=%h exp=a5c3", word[0]); end
        checks++;
        if (all_ones[0] !== 1'b0) begin fails++; $display("FAIL b2b_all_ones got=%b exp=0", all_ones[0]); end
        checks++;
        if (par_err[0] !== exp_par(16'hA5C3, 1'b0)) begin
            fails++; $display("FAIL b2b_par got=%b exp=%b", par_err[0], exp_par(16'hA5C3, 1'b0));
        end
        tick();
        checks++;
        if (word_valid[0] !== 1'b0 || word[0] !== 16'h0000) begin
            fails++; $display("FAIL b2b_one_cycle got valid=%b word=%h exp valid=0 word=0000", word_valid[0], word[0]);
        end
    endtask

    task automatic test_hold_stall();
        word_ready[0] = 1'b0;
        send_word(0, 16'hFFFF, 3, 1'b0);
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (word_valid[0] !== 1'b1 || word[0] !== 16'hFFFF || all_ones[0] !== 1'b1 || bit_ready[0] !== 1'b0) begin
                fails++;
                $display("FAIL hold_stall cyc=%0d got valid=%b word=%h ones=%b ready=%b exp 1 ffff 1 0",
                         k, word_valid[0], word[0], all_ones[0], bit_ready[0]);
            end
            bit_valid[0] = 1'b1;
            bit_in[0]    = 1'($urandom);
            tick();
        end
        bit_valid[0]  = 1'b0;
        word_ready[0] = 1'b1;
        tick();
        checks++;
        if (word_valid[0] !== 1'b0 || all_ones[0] !== 1'b0) begin
            fails++; $display("FAIL hold_release got valid=%b ones=%b exp 0 0", word_valid[0], all_ones[0]);
        end
        word_ready[0] = 1'b0;
    endtask

    task automatic test_msb_first();
        word_ready[1] = 1'b1;
        send_word(1, 16'h8001, 0, 1'b0);
        checks++;
        if (word_valid[1] !== 1'b1 || word[1] !== 16'h8001) begin
            fails++; $display("FAIL msb_first got valid=%b word=%h exp 1 8001", word_valid[1], word[1]);
        end
        tick();
        word_ready[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        word_ready[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bit_valid[0] = 1'b1;
            bit_in[0]    = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (word[0] !== 16'h0000 || word_valid[0] !== 1'b0) begin
            fails++; $display("FAIL reset_mid_clear got word=%h valid=%b exp 0000 0", word[0], word_valid[0]);
        end
        rst          = 1'b0;
        bit_valid[0] = 1'b0;
        send_word(0, 16'h1234, 1, 1'b1);
        checks++;
        if (word_valid[0] !== 1'b1 || word[0] !== 16'h1234) begin
            fails++; $display("FAIL reset_mid_word got valid=%b word=%h exp 1 1234", word_valid[0], word[0]);
        end
        tick();
    endtask

    task automatic test_parity();
        word_ready[0] = 1'b0;
        send_word(0, 16'h0003, 0, 1'b1);
        checks++;
        if (word[0] !== 16'h0003 || par_err[0] !== exp_par(16'h0003, 1'b1)) begin
            fails++; $display("FAIL parity_bad got word=%h perr=%b exp 0003 %b", word[0], par_err[0], exp_par(16'h0003, 1'b1));
        end
        word_ready[0] = 1'b1;
        tick();
        word_ready[0] = 1'b0;
        send_word(0, 16'h0003, 0, 1'b0);
        checks++;
        if (word[0] !== 16'h0003 || par_err[0] !== 1'b0) begin
            fails++; $display("FAIL parity_good got word=%h perr=%b exp 0003 0", word[0], par_err[0]);
        end
        word_ready[0] = 1'b1;
        tick();
        word_ready[0] = 1'b0;
    endtask

    task automatic test_drain();
        word_ready[0] = 1'b0;
        send_word(0, 16'h00F0, 0, 1'b0);
        tick();
        tick();
        word_ready[0] = 1'b1;
        bit_valid[0]  = 1'b1;
        bit_in[0]     = 1'b1;
        tick();
        checks++;
        if (word_valid[0] !== 1'b0 || word[0] !== 16'h0000) begin
            fails++; $display("FAIL drain_no_accept got valid=%b word=%h exp 0 0000", word_valid[0], word[0]);
        end
        bit_valid[0] = 1'b0;
        send_word(0, 16'h4C2A, 0, 1'b0);
        checks++;
        if (word_valid[0] !== 1'b1 || word[0] !== 16'h4C2A) begin
            fails++; $display("FAIL drain_next_word got valid=%b word=%h exp 1 4c2a", word_valid[0], word[0]);
        end
        tick();
        word_ready[0] = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int          sel;
            logic [15:0] data;
            logic        pbit;
            sel  = int'($urandom_range(1, 0));
            data = (n == 5) ? 16'hFFFF : 16'($urandom);
            pbit = 1'($urandom);
            word_ready[sel] = 1'b0;
            send_word(sel, data, 2, pbit);
            repeat ($urandom_range(3, 0)) tick();
            checks++;
            if (word_valid[sel] !== 1'b1 || word[sel] !== data || all_ones[sel] !== (data == 16'hFFFF)
                || par_err[sel] !== exp_par(data, pbit)) begin
                fails++;
                $display("FAIL random[%0d] sel=%0d got valid=%b word=%h ones=%b perr=%b exp 1 %h %b %b",
                         n, sel, word_valid[sel], word[sel], all_ones[sel], par_err[sel],
                         data, (data == 16'hFFFF), exp_par(data, pbit));
            end
            word_ready[sel] = 1'b1;
            tick();
            word_ready[sel] = 1'b0;
            checks++;
            if (word_valid[sel] !== 1'b0) begin fails++; $display("FAIL random_drain[%0d] got=%b exp=0", n, word_valid[sel]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold_stall();
        test_msb_first();
        test_reset_mid();
        test_parity();
        test_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_deser16
`default_nettype wire
